alu_seq: RTL and testbench

- Parametrised, clocked successor to the team's combinational N-bit ALU.
- Adds valid/ready handshakes on both sides, registered results and flags, XOR and shift operations, and an iterative signed multiply producing a double-width product.
- Adds a carry/borrow flag and a sticky overflow flag that software can clear.
- Sits between an operand-issue stage and a result-consumer stage in the datapath.

---
 rtl/alu_seq_if.sv | 34 +++
 rtl/alu_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for alu_seq
interface alu_seq_if #(
    parameter int data_width = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [data_width-1:0] A;
    logic [data_width-1:0] B;
    logic [2:0]            control;
    logic                  out_valid;
    logic                  out_ready;
    logic [data_width-1:0] R;
    logic [data_width-1:0] R_hi;
    logic                  ovflag;
    logic                  carryflag;
    logic                  signflag;
    logic                  zeroflag;
    logic                  sticky_ov;
    logic                  clr_sticky;

    // Issue stage and result consumer side
    modport master (
        output in_valid, A, B, control, out_ready, clr_sticky,
        input  in_ready, out_valid, R, R_hi, ovflag, carryflag, signflag,
               zeroflag, sticky_ov
    );

    // ALU side
    modport slave (
        input  in_valid, A, B, control, out_ready, clr_sticky,
        output in_ready, out_valid, R, R_hi, ovflag, carryflag, signflag,
               zeroflag, sticky_ov
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - clocked ALU with handshakes, flags, sticky overflow and iterative signed multiply
module alu_seq #(
    parameter int data_width = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int sh_width = $clog2(data_width);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                    state_q, state_d;
    logic [data_width-1:0]     r_q, r_d;
    logic [data_width-1:0]     r_hi_q, r_hi_d;
    logic                      ov_q, ov_d;
    logic                      carry_q, carry_d;
    logic                      sign_q, sign_d;
    logic                      zero_q, zero_d;
    logic                      sticky_q, sticky_d;
    // Multiplier working set: sign-extended multiplicand shifted left each
    // step, multiplier shifted right, running double-width accumulator.
    logic [2*data_width-1:0]   mcand_q, mcand_d;
    logic [data_width-1:0]     mplier_q, mplier_d;
    logic [2*data_width-1:0]   acc_q, acc_d;
    logic [sh_width-1:0]       cnt_q, cnt_d;

    logic                      in_ready;
    logic                      accept;
    logic                      mul_last;
    logic [2*data_width-1:0]   mul_sum;

    logic [data_width-1:0]     alu_r;
    logic                      alu_carry;
    logic                      alu_ov;
    logic [data_width:0]       add_ext;
    logic [data_width:0]       sub_ext;
    logic [data_width:0]       sll_ext;
    logic signed [data_width:0] sra_ext;
    logic [sh_width-1:0]       sh_amt;

    // New work is taken when idle, or when the held result leaves this cycle
    assign in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;
    assign mul_last = (cnt_q == sh_width'(data_width - 1));

    // Single-cycle operations evaluated directly on the incoming operands
    always_comb begin
        alu_r     = '0;
        alu_carry = 1'b0;
        alu_ov    = 1'b0;
        sh_amt    = bus.B[sh_width-1:0];
        add_ext   = {1'b0, bus.A} + {1'b0, bus.B};
        sub_ext   = {1'b0, bus.A} - {1'b0, bus.B};
        // Extra guard bit on the far side of the shift catches the last bit
        // shifted out; it stays 0 for a zero shift amount.
        sll_ext   = {1'b0, bus.A} << sh_amt;
        sra_ext   = $signed({bus.A, 1'b0}) >>> sh_amt;
        case (bus.control)
            OP_ADD: begin
                alu_r     = add_ext[data_width-1:0];
                alu_carry = add_ext[data_width];
                alu_ov    = (bus.A[data_width-1] == bus.B[data_width-1]) &&
                            (alu_r[data_width-1] != bus.A[data_width-1]);
            end
            OP_SUB: begin
                alu_r     = sub_ext[data_width-1:0];
                alu_carry = sub_ext[data_width];
                alu_ov    = (bus.A[data_width-1] != bus.B[data_width-1]) &&
                            (alu_r[data_width-1] != bus.A[data_width-1]);
            end
            OP_AND: alu_r = bus.A & bus.B;
            OP_OR:  alu_r = bus.A | bus.B;
            OP_XOR: alu_r = bus.A ^ bus.B;
            OP_SLL: begin
                alu_r     = sll_ext[data_width-1:0];
                alu_carry = sll_ext[data_width];
            end
            OP_SRA: begin
                alu_r     = sra_ext[data_width:1];
                alu_carry = sra_ext[0];
            end
            default: alu_r = '0;
        endcase
    end

    // One shift-add step; the MSB of the multiplier carries negative weight
    always_comb begin
        mul_sum = acc_q;
        if (mplier_q[0]) begin
            if (mul_last) begin
                mul_sum = acc_q - mcand_q;
            end else begin
                mul_sum = acc_q + mcand_q;
            end
        end
    end

    // Next-state, result capture and sticky overflow
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        r_hi_d   = r_hi_q;
        ov_d     = ov_q;
        carry_d  = carry_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        sticky_d = sticky_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: state_d = IDLE;
            EXEC: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + sh_width'(1);
                if (mul_last) begin
                    state_d = DONE;
                    r_d     = mul_sum[data_width-1:0];
                    r_hi_d  = mul_sum[2*data_width-1:data_width];
                    ov_d    = (mul_sum[2*data_width-1:data_width] !=
                               {data_width{mul_sum[data_width-1]}});
                    carry_d = 1'b0;
                    sign_d  = mul_sum[data_width-1];
                    zero_d  = (mul_sum == '0);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Acceptance overrides the DONE->IDLE return for back-to-back issue
        if (accept) begin
            if (bus.control == OP_MUL) begin
                state_d  = EXEC;
                mcand_d  = {{data_width{bus.A[data_width-1]}}, bus.A};
                mplier_d = bus.B;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                state_d = DONE;
                r_d     = alu_r;
                r_hi_d  = '0;
                ov_d    = alu_ov;
                carry_d = alu_carry;
                sign_d  = alu_r[data_width-1];
                zero_d  = (alu_r == '0);
            end
        end

        // Clear first so a same-cycle overflow handoff wins
        if (bus.clr_sticky) begin
            sticky_d = 1'b0;
        end
        if ((state_q == DONE) && bus.out_ready && ov_q) begin
            sticky_d = 1'b1;
        end
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            r_q      <= '0;
            r_hi_q   <= '0;
            ov_q     <= 1'b0;
            carry_q  <= 1'b0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            sticky_q <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            r_hi_q   <= r_hi_d;
            ov_q     <= ov_d;
            carry_q  <= carry_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            sticky_q <= sticky_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.R         = r_q;
    assign bus.R_hi      = r_hi_q;
    assign bus.ovflag    = ov_q;
    assign bus.carryflag = carry_q;
    assign bus.signflag  = sign_q;
    assign bus.zeroflag  = zero_q;
    assign bus.sticky_ov = sticky_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    alu_seq_if #(.data_width(16)) bus ();

    alu_seq #(.data_width(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, wanted finish");
        $fatal(1, "watchdog");
    end

    // Presents one op, waits for acceptance and then for the result; out_ready held low
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output bit rdy_busy);
        int guard;
        bus.control  = op;
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        rdy_busy = 1'b0;
        guard = 0;
        #1;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.A = 16'hA5A5;
        bus.B = 16'h5A5A;
        bus.control = 3'b010;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) rdy_busy = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handoff();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready);
        end
        n_tests++;
        if ({bus.out_valid, bus.R, bus.R_hi, bus.ovflag, bus.carryflag, bus.signflag,
             bus.zeroflag, bus.sticky_ov} !== 39'd0) begin
            n_fail++; $display("FAIL reset_outputs: got ov=%0b R=%h Rhi=%h flags=%0b%0b%0b%0b st=%0b want all 0",
                bus.out_valid, bus.R, bus.R_hi, bus.ovflag, bus.carryflag, bus.signflag,
                bus.zeroflag, bus.sticky_ov);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %0b want 1", bus.in_ready);
        end
    endtask

    task automatic test_add_sub();
        int lat; bit rb;
        run_op(3'b000, 16'h7FFF, 16'h0001, lat, rb);
        n_tests++;
        if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", lat); end
        n_tests++;
        if ({bus.R, bus.R_hi, bus.ovflag, bus.signflag, bus.carryflag, bus.zeroflag} !== {16'h8000, 16'h0000, 4'b1100}) begin
            n_fail++; $display("FAIL add_ovf: got R=%h Rhi=%h o/s/c/z=%0b%0b%0b%0b want R=8000 Rhi=0000 1100",
                bus.R, bus.R_hi, bus.ovflag, bus.signflag, bus.carryflag, bus.zeroflag);
        end
        handoff();
        run_op(3'b001, 16'h0000, 16'h0001, lat, rb);
        n_tests++;
        if ({bus.R, bus.carryflag, bus.ovflag, bus.signflag, bus.zeroflag} !== {16'hFFFF, 4'b1010}) begin
            n_fail++; $display("FAIL sub_borrow: got R=%h c/o/s/z=%0b%0b%0b%0b want R=ffff 1010",
                bus.R, bus.carryflag, bus.ovflag, bus.signflag, bus.zeroflag);
        end
        handoff();
        run_op(3'b000, 16'hFFFF, 16'h0001, lat, rb);
        n_tests++;
        if ({bus.R, bus.carryflag, bus.ovflag, bus.zeroflag} !== {16'h0000, 3'b101}) begin
            n_fail++; $display("FAIL add_carry_zero: got R=%h c/o/z=%0b%0b%0b want R=0000 101",
                bus.R, bus.carryflag, bus.ovflag, bus.zeroflag);
        end
        handoff();
        run_op(3'b001, 16'h8000, 16'h0001, lat, rb);
        n_tests++;
        if ({bus.R, bus.carryflag, bus.ovflag} !== {16'h7FFF, 2'b01}) begin
            n_fail++; $display("FAIL sub_ovf: got R=%h c/o=%0b%0b want R=7fff 01", bus.R, bus.carryflag, bus.ovflag);
        end
        handoff();
    endtask

    task automatic test_logic();
        int lat; bit rb;
        logic [2:0]  ops [3] = '{3'b010, 3'b011, 3'b100};
        logic [15:0] exp [3] = '{16'hF000, 16'hFFF0, 16'h0FF0};
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 16'hF0F0, 16'hFF00, lat, rb);
            n_tests++;
            if ({bus.R, bus.ovflag, bus.carryflag, bus.zeroflag} !== {exp[i], 3'b000}) begin
                n_fail++; $display("FAIL logic_op%0d: got R=%h o/c/z=%0b%0b%0b want R=%h 000",
                    i, bus.R, bus.ovflag, bus.carryflag, bus.zeroflag, exp[i]);
            end
            handoff();
        end
        run_op(3'b100, 16'h1234, 16'h1234, lat, rb);
        n_tests++;
        if ({bus.R, bus.zeroflag, bus.signflag} !== {16'h0000, 2'b10}) begin
            n_fail++; $display("FAIL xor_zero: got R=%h z/s=%0b%0b want R=0000 10", bus.R, bus.zeroflag, bus.signflag);
        end
        handoff();
    endtask

    task automatic test_shift();
        int lat; bit rb;
        run_op(3'b101, 16'h8001, 16'h0011, lat, rb);
        n_tests++;
        if ({bus.R, bus.carryflag, bus.ovflag, bus.R_hi} !== {16'h0002, 2'b10, 16'h0000}) begin
            n_fail++; $display("FAIL sll_1: got R=%h c/o=%0b%0b Rhi=%h want R=0002 10 Rhi=0000",
                bus.R, bus.carryflag, bus.ovflag, bus.R_hi);
        end
        handoff();
        run_op(3'b110, 16'h8000, 16'h000F, lat, rb);
        n_tests++;
        if ({bus.R, bus.carryflag, bus.signflag} !== {16'hFFFF, 2'b01}) begin
            n_fail++; $display("FAIL sra_15: got R=%h c/s=%0b%0b want R=ffff 01", bus.R, bus.carryflag, bus.signflag);
        end
        handoff();
        run_op(3'b110, 16'h0003, 16'h0002, lat, rb);
        n_tests++;
        if ({bus.R, bus.carryflag, bus.zeroflag} !== {16'h0000, 2'b11}) begin
            n_fail++; $display("FAIL sra_out: got R=%h c/z=%0b%0b want R=0000 11", bus.R, bus.carryflag, bus.zeroflag);
        end
        handoff();
        run_op(3'b101, 16'h9234, 16'h0010, lat, rb);
        n_tests++;
        if ({bus.R, bus.carryflag} !== {16'h9234, 1'b0}) begin
            n_fail++; $display("FAIL sll_0: got R=%h c=%0b want R=9234 0", bus.R, bus.carryflag);
        end
        handoff();
        run_op(3'b110, 16'h8001, 16'h0000, lat, rb);
        n_tests++;
        if ({bus.R, bus.carryflag} !== {16'h8001, 1'b0}) begin
            n_fail++; $display("FAIL sra_0: got R=%h c=%0b want R=8001 0", bus.R, bus.carryflag);
        end
        handoff();
    endtask

    task automatic test_mul();
        int lat; bit rb;
        run_op(3'b111, 16'hFFFD, 16'h0005, lat, rb);
        n_tests++;
        if (lat !== 17) begin n_fail++; $display("FAIL mul_latency: got %0d want 17", lat); end
        n_tests++;
        if (rb !== 1'b0) begin n_fail++; $display("FAIL mul_in_ready_exec: got in_ready high during EXEC, want low"); end
        n_tests++;
        if ({bus.R, bus.R_hi, bus.ovflag, bus.carryflag, bus.signflag, bus.zeroflag} !== {16'hFFF1, 16'hFFFF, 4'b0010}) begin
            n_fail++; $display("FAIL mul_neg: got R=%h Rhi=%h o/c/s/z=%0b%0b%0b%0b want R=fff1 Rhi=ffff 0010",
                bus.R, bus.R_hi, bus.ovflag, bus.carryflag, bus.signflag, bus.zeroflag);
        end
        handoff();
        run_op(3'b111, 16'h0100, 16'h0100, lat, rb);
        n_tests++;
        if ({bus.R, bus.R_hi, bus.ovflag, bus.zeroflag} !== {16'h0000, 16'h0001, 2'b10}) begin
            n_fail++; $display("FAIL mul_ovf: got R=%h Rhi=%h o/z=%0b%0b want R=0000 Rhi=0001 10",
                bus.R, bus.R_hi, bus.ovflag, bus.zeroflag);
        end
        handoff();
        run_op(3'b111, 16'h8000, 16'h8000, lat, rb);
        n_tests++;
        if ({bus.R, bus.R_hi, bus.ovflag} !== {16'h0000, 16'h4000, 1'b1}) begin
            n_fail++; $display("FAIL mul_minmin: got R=%h Rhi=%h o=%0b want R=0000 Rhi=4000 1",
                bus.R, bus.R_hi, bus.ovflag);
        end
        handoff();
        run_op(3'b111, 16'h0000, 16'h7FFF, lat, rb);
        n_tests++;
        if ({bus.R, bus.R_hi, bus.zeroflag, bus.ovflag} !== {32'h0, 2'b10}) begin
            n_fail++; $display("FAIL mul_zero: got R=%h Rhi=%h z/o=%0b%0b want 0 0 10",
                bus.R, bus.R_hi, bus.zeroflag, bus.ovflag);
        end
        handoff();
    endtask

    task automatic test_back_to_back();
        int lat; bit rb;
        logic [15:0] exp_r;
        run_op(3'b000, 16'h0001, 16'h0002, lat, rb);
        bus.in_valid = 1'b1;
        bus.control  = 3'b001;
        bus.A = 16'h0009; bus.B = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if ({bus.out_valid, bus.in_ready, bus.R, bus.ovflag, bus.carryflag, bus.zeroflag} !== {2'b10, 16'h0003, 3'b000}) begin
                n_fail++; $display("FAIL backpressure_c%0d: got v/rdy=%0b%0b R=%h o/c/z=%0b%0b%0b want 10 R=0003 000",
                    i, bus.out_valid, bus.in_ready, bus.R, bus.ovflag, bus.carryflag, bus.zeroflag);
            end
            @(posedge clk); #1;
            bus.A = bus.A + 16'h0011;
        end
        bus.out_ready = 1'b1;
        bus.control   = 3'b000;
        for (int k = 0; k < 4; k++) begin
            bus.A = 16'h0100;
            bus.B = 16'h0001 + 16'(k);
            #1;
            n_tests++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_ready%0d: got %0b want 1", k, bus.in_ready);
            end
            @(posedge clk); #1;
            exp_r = 16'h0101 + 16'(k);
            n_tests++;
            if ({bus.out_valid, bus.R} !== {1'b1, exp_r}) begin
                n_fail++; $display("FAIL b2b_result%0d: got v=%0b R=%h want v=1 R=%h", k, bus.out_valid, bus.R, exp_r);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: got out_valid=%0b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_mul();
        int lat; bit rb;
        bus.control = 3'b111; bus.A = 16'h0100; bus.B = 16'h0100;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({bus.out_valid, bus.in_ready, bus.R, bus.R_hi, bus.ovflag, bus.carryflag, bus.signflag,
             bus.zeroflag, bus.sticky_ov} !== 39'd0) begin
            n_fail++; $display("FAIL reset_mid_mul: got v=%0b rdy=%0b R=%h Rhi=%h flags=%0b%0b%0b%0b st=%0b want all 0",
                bus.out_valid, bus.in_ready, bus.R, bus.R_hi, bus.ovflag, bus.carryflag,
                bus.signflag, bus.zeroflag, bus.sticky_ov);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_mul_ready: got %0b want 1", bus.in_ready);
        end
        run_op(3'b000, 16'h0002, 16'h0003, lat, rb);
        n_tests++;
        if ({lat[7:0], bus.R, bus.R_hi} !== {8'd1, 16'h0005, 16'h0000}) begin
            n_fail++; $display("FAIL post_reset_add: got lat=%0d R=%h Rhi=%h want lat=1 R=0005 Rhi=0000",
                lat, bus.R, bus.R_hi);
        end
        handoff();
    endtask

    task automatic test_sticky();
        int lat; bit rb;
        n_tests++;
        if (bus.sticky_ov !== 1'b0) begin
            n_fail++; $display("FAIL sticky_start: got %0b want 0", bus.sticky_ov);
        end
        run_op(3'b000, 16'h7FFF, 16'h0001, lat, rb);
        n_tests++;
        if (bus.sticky_ov !== 1'b0) begin
            n_fail++; $display("FAIL sticky_before_handoff: got %0b want 0", bus.sticky_ov);
        end
        handoff();
        n_tests++;
        if (bus.sticky_ov !== 1'b1) begin
            n_fail++; $display("FAIL sticky_set: got %0b want 1", bus.sticky_ov);
        end
        run_op(3'b001, 16'h8000, 16'h0001, lat, rb);
        bus.clr_sticky = 1'b1;
        handoff();
        bus.clr_sticky = 1'b0;
        n_tests++;
        if (bus.sticky_ov !== 1'b1) begin
            n_fail++; $display("FAIL sticky_set_wins: got %0b want 1", bus.sticky_ov);
        end
        bus.clr_sticky = 1'b1;
        @(posedge clk); #1;
        bus.clr_sticky = 1'b0;
        n_tests++;
        if (bus.sticky_ov !== 1'b0) begin
            n_fail++; $display("FAIL sticky_clear: got %0b want 0", bus.sticky_ov);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.in_valid   = 1'b0;
        bus.A          = '0;
        bus.B          = '0;
        bus.control    = '0;
        bus.out_ready  = 1'b0;
        bus.clr_sticky = 1'b0;
        test_reset();
        test_add_sub();
        test_logic();
        test_shift();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_sticky();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
